// File: rtl/ibuf_queue.sv
// Byte-granular instruction buffer between the I-cache fill path and decode.
// Accepts up to four bytes per cycle and presents the oldest seven bytes with a thermometer valid vector.
module ibuf_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          icu_wr_vld,
  input  logic [31:0]   icu_wr_data,
  input  logic [2:0]    icu_wr_nbytes,
  input  logic [2:0]    iu_shift_cnt,
  input  logic          iu_flush,
  output logic [55:0]   ibuf_data,
  output logic [6:0]    fetch_valid,
  output logic [CW-1:0] ibuf_count,
  output logic          ibuf_full,
  output logic          ibuf_ovf_err
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt, shift_eff, wr_bytes;
  logic          nbytes_ok, wr_accept, wr_drop, over_shift, err_nxt;

  // Acceptance looks at the start-of-cycle full flag only; room freed by a
  // concurrent shift is not credited until the next cycle.
  always_comb begin
    nbytes_ok  = (icu_wr_nbytes != 3'd0) && (icu_wr_nbytes <= 3'd4);
    wr_accept  = icu_wr_vld && nbytes_ok && !ibuf_full && !iu_flush;
    wr_drop    = icu_wr_vld && nbytes_ok && ibuf_full && !iu_flush;
    over_shift = !iu_flush && (CW'(iu_shift_cnt) > cnt);
    shift_eff  = over_shift ? cnt : CW'(iu_shift_cnt);
    wr_bytes   = wr_accept ? CW'(icu_wr_nbytes) : '0;
    err_nxt    = ibuf_ovf_err | over_shift | wr_drop;
    if (iu_flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      cnt_nxt    = '0;
    end else begin
      rd_ptr_nxt = rd_ptr + AW'(shift_eff);
      wr_ptr_nxt = wr_ptr + AW'(wr_bytes);
      cnt_nxt    = cnt - shift_eff + wr_bytes;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      ibuf_ovf_err <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_nxt;
      wr_ptr       <= wr_ptr_nxt;
      cnt          <= cnt_nxt;
      ibuf_ovf_err <= err_nxt;
    end
  end

  // Storage is not reset; stale bytes are masked by the valid vector.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(icu_wr_nbytes))
          mem[wr_ptr + AW'(k)] <= icu_wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 7; i++)
      fetch_valid[i] = (cnt > CW'(i));
  end

  always_comb begin
    for (int i = 0; i < 7; i++)
      ibuf_data[8*i +: 8] = (cnt > CW'(i)) ? mem[rd_ptr + AW'(i)] : 8'h00;
  end

  assign ibuf_count = cnt;
  assign ibuf_full  = (cnt > CW'(DEPTH - 4));

endmodule

// File: tb/tb_ibuf_queue.sv
// Scoreboard bench for ibuf_queue: stimulus pushes hand-computed expectations,
// a monitor on the falling edge pops and compares them.
module tb_ibuf_queue;

  logic        clk;
  logic        reset_l;
  logic        icu_wr_vld;
  logic [31:0] icu_wr_data;
  logic [2:0]  icu_wr_nbytes;
  logic [2:0]  iu_shift_cnt;
  logic        iu_flush;
  logic [55:0] ibuf_data;
  logic [6:0]  fetch_valid;
  logic [4:0]  ibuf_count;
  logic        ibuf_full;
  logic        ibuf_ovf_err;

  typedef struct {
    string       name;
    int          due;
    logic [4:0]  count;
    logic [6:0]  fv;
    logic [55:0] data;
    logic        full;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  ibuf_queue #(.DEPTH(16), .CW(5)) dut (
    .clk           (clk),
    .reset_l       (reset_l),
    .icu_wr_vld    (icu_wr_vld),
    .icu_wr_data   (icu_wr_data),
    .icu_wr_nbytes (icu_wr_nbytes),
    .iu_shift_cnt  (iu_shift_cnt),
    .iu_flush      (iu_flush),
    .ibuf_data     (ibuf_data),
    .fetch_valid   (fetch_valid),
    .ibuf_count    (ibuf_count),
    .ibuf_full     (ibuf_full),
    .ibuf_ovf_err  (ibuf_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string tag, input string field, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "count", 64'(ibuf_count), 64'(e.count));
    cmp(e.name, "fetch_valid", 64'(fetch_valid), 64'(e.fv));
    cmp(e.name, "data", 64'(ibuf_data), 64'(e.data));
    cmp(e.name, "full", 64'(ibuf_full), 64'(e.full));
    cmp(e.name, "ovf_err", 64'(ibuf_ovf_err), 64'(e.err));
  endtask

  // Called on a falling edge; returns on the next falling edge after the DUT has clocked.
  task automatic applyStimulus(input string name, input logic vld, input logic [31:0] data,
                               input logic [2:0] nb, input logic [2:0] sh, input logic fl,
                               input logic [4:0] ecnt, input logic [6:0] efv,
                               input logic [55:0] edata, input logic efull, input logic eerr);
    exp_t e;
    icu_wr_vld    = vld;
    icu_wr_data   = data;
    icu_wr_nbytes = nb;
    iu_shift_cnt  = sh;
    iu_flush      = fl;
    e.name  = name;
    e.due   = cyc + 1;
    e.count = ecnt;
    e.fv    = efv;
    e.data  = edata;
    e.full  = efull;
    e.err   = eerr;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    icu_wr_vld    = 1'b0;
    icu_wr_data   = 32'h0;
    icu_wr_nbytes = 3'd0;
    iu_shift_cnt  = 3'd0;
    iu_flush      = 1'b0;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d pending required=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic checkReset(input string name);
    exp_t e;
    e.name  = name;
    e.due   = 0;
    e.count = 5'd0;
    e.fv    = 7'h00;
    e.data  = 56'h0;
    e.full  = 1'b0;
    e.err   = 1'b0;
    checkOutput(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_l = 1'b0;
    idleInputs();
    #1;
    checkReset("reset");
    repeat (2) @(negedge clk);
    reset_l = 1'b1;

    applyStimulus("fill4", 1, 32'h44332211, 3'd4, 3'd0, 0, 5'd4, 7'h0F, 56'h00000044332211, 0, 0);
    applyStimulus("shift_wr", 1, 32'h00006655, 3'd2, 3'd3, 0, 5'd3, 7'h07, 56'h00000000665544, 0, 0);
    applyStimulus("fill_a", 1, 32'h73727170, 3'd4, 3'd0, 0, 5'd7, 7'h7F, 56'h73727170665544, 0, 0);
    applyStimulus("fill_b", 1, 32'h83828180, 3'd4, 3'd0, 0, 5'd11, 7'h7F, 56'h73727170665544, 0, 0);
    applyStimulus("fill_c12", 1, 32'hDEADBE90, 3'd1, 3'd0, 0, 5'd12, 7'h7F, 56'h73727170665544, 0, 0);
    applyStimulus("fill_d16", 1, 32'hB3B2B1B0, 3'd4, 3'd0, 0, 5'd16, 7'h7F, 56'h73727170665544, 1, 0);
    applyStimulus("drop", 1, 32'hCCCCCCCC, 3'd4, 3'd0, 0, 5'd16, 7'h7F, 56'h73727170665544, 1, 1);
    applyStimulus("shift7", 0, 32'h0, 3'd0, 3'd7, 0, 5'd9, 7'h7F, 56'hB1B09083828180, 0, 1);
    applyStimulus("shift4", 0, 32'h0, 3'd0, 3'd4, 0, 5'd5, 7'h1F, 56'h0000B3B2B1B090, 0, 1);
    applyStimulus("wrap_wr", 1, 32'hA3A2A1A0, 3'd4, 3'd0, 0, 5'd9, 7'h7F, 56'hA1A0B3B2B1B090, 0, 1);
    applyStimulus("wrap_sh", 0, 32'h0, 3'd0, 3'd5, 0, 5'd4, 7'h0F, 56'h000000A3A2A1A0, 0, 1);
    idleInputs();
    waitDrain();

    reset_l = 1'b0;
    #1;
    checkReset("reset_mid");
    @(negedge clk);
    reset_l = 1'b1;

    applyStimulus("nb0", 1, 32'h12345678, 3'd0, 3'd0, 0, 5'd0, 7'h00, 56'h0, 0, 0);
    applyStimulus("nb5", 1, 32'h12345678, 3'd5, 3'd0, 0, 5'd0, 7'h00, 56'h0, 0, 0);
    applyStimulus("fill2", 1, 32'h00002221, 3'd2, 3'd0, 0, 5'd2, 7'h03, 56'h00000000002221, 0, 0);
    applyStimulus("overshift", 0, 32'h0, 3'd0, 3'd5, 0, 5'd0, 7'h00, 56'h0, 0, 1);
    applyStimulus("fill4b", 1, 32'h34333231, 3'd4, 3'd0, 0, 5'd4, 7'h0F, 56'h00000034333231, 0, 1);
    applyStimulus("flush", 1, 32'hEEEEEEEE, 3'd4, 3'd2, 1, 5'd0, 7'h00, 56'h0, 0, 1);
    applyStimulus("post_flush", 1, 32'h00005B5A, 3'd2, 3'd0, 0, 5'd2, 7'h03, 56'h00000000005B5A, 0, 1);
    idleInputs();
    waitDrain();

    #3;
    reset_l = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibuf_queue.md
# ibuf_queue

Byte-granular instruction buffer between the instruction-cache fill path and the decode/fold logic. It queues instruction bytes written up to four per cycle. It presents the oldest seven bytes with a contiguous valid vector (`fetch_valid[6:0]`) to the length decoder and decode-valid logic, and retires a variable number of bytes per cycle as the pipeline consumes them. It is the stage directly upstream of the decode-valid generation.

## Interface

Parameters:

- `DEPTH`, default 16: byte capacity. Must be a power of 2 and at least 8.
- `CW`, default 5: count width, equal to log2(DEPTH)+1.

Ports:

- `clk`  in  1  — the one clock for the block.
- `reset_l`  in  1  — asynchronous, active-low reset.
- `icu_wr_vld`  in  1  — write request this cycle.
- `icu_wr_data`  in  32  — write bytes. Byte 0 is in [7:0] and is the oldest in program order.
- `icu_wr_nbytes`  in  3  — number of valid bytes in `icu_wr_data`, 1–4, taken from byte 0 upward. A value of 0 or greater than 4 makes the write a no-op.
- `iu_shift_cnt`  in  3  — bytes consumed this cycle, 0–7.
- `iu_flush`  in  1  — discard all contents. Used for branch, trap and redirect.
- `ibuf_data`  out  56  — oldest seven bytes. Byte i is in [8i+7:8i].
- `fetch_valid`  out  7  — bit i set when byte i holds a valid byte.
- `ibuf_count`  out  CW  — number of valid bytes held.
- `ibuf_full`  out  1  — set when fewer than 4 free bytes remain.
- `ibuf_ovf_err`  out  1  — sticky error flag.

## Operation

Storage and state:
- Circular byte array of DEPTH entries, with read pointer `rd_ptr` and write pointer `wr_ptr`, each log2(DEPTH) bits and wrapping modulo DEPTH.
- Registered count `cnt`, CW bits.

Cycle ordering: flush, then shift, then write.

- **Flush:**
  - `iu_flush`=1 sets next `rd_ptr`=`wr_ptr`=0 and `cnt`=0.
  - A write or shift in the same cycle is ignored.
- **Shift:**
  - Effective shift is `s` = min(`iu_shift_cnt`, `cnt`).
  - If `iu_shift_cnt` > `cnt`, set `ibuf_ovf_err`; the clamped shift still applies.
  - `rd_ptr` += `s`.
- **Write:**
  - A write is accepted when `icu_wr_vld`=1, `icu_wr_nbytes` is 1–4, and `ibuf_full`=0 at the start of the cycle.
  - Acceptance is judged on the start-of-cycle value, not the post-shift room.
  - An accepted write stores byte k at `wr_ptr`+k for k < `icu_wr_nbytes`, then `wr_ptr` += `icu_wr_nbytes`.
  - A write presented while `ibuf_full`=1 is dropped and sets `ibuf_ovf_err`. The fill logic must hold off on `ibuf_full`.
- **Count:** next `cnt` = `cnt` − `s` + (accepted ? `icu_wr_nbytes` : 0). It never exceeds DEPTH.
- **Full:** `ibuf_full` = (`cnt` > DEPTH−4). This is decoded combinationally from the registered `cnt`.
- **Outputs:**
  - `fetch_valid[i]` = (`cnt` > i). The vector is always thermometer-contiguous from bit 0.
  - `ibuf_data` byte i = array[`rd_ptr`+i] when `fetch_valid[i]`=1, otherwise 8'h00.
  - `ibuf_count` = `cnt`.
- **Error flag:** `ibuf_ovf_err` is sticky until reset; flush does not clear it.

## Timing

- **Reset:** while `reset_l`=0, asynchronously set `rd_ptr`=`wr_ptr`=0, `cnt`=0 and `ibuf_ovf_err`=0. This gives `fetch_valid`=7'h00, `ibuf_data`=0, `ibuf_count`=0 and `ibuf_full`=0. Array contents are not reset.
- **Write latency:** 1 cycle. Bytes accepted at edge N are visible on `ibuf_data`/`fetch_valid` after edge N.
- **Shift latency:** 1 cycle. The output window advances after the edge.
- **Combinational paths:** all outputs are functions of registered state only. There is no input-to-output path.
- **Simultaneous shift and write:** both apply. New bytes land after the surviving bytes, in order.
- **Wrap-around:** pointer arithmetic is modulo DEPTH. A write or output window that straddles the wrap must be byte-exact.
- **Reset mid-operation:** contents are lost and the outputs return to their reset values immediately.

## Test plan

1. **Reset, then fill:** reset, then write 4 bytes 0x11,0x22,0x33,0x44 (nbytes=4). Next cycle: `fetch_valid`=7'h0F, `ibuf_data`[31:0]=0x44332211, `ibuf_count`=4.
2. **Shift with concurrent write:** from state 1, apply shift=3 together with a write of 2 bytes 0x55,0x66. Next cycle: `ibuf_count`=3, bytes 0x44,0x55,0x66, `fetch_valid`=7'h07.
3. **Full and dropped write:**
   - Write 4 bytes per cycle with no shift until `ibuf_full`=1 at `cnt`=16 (DEPTH=16).
   - Present a further write: it is dropped, `ibuf_ovf_err`=1, and `cnt` stays at 16.
4. **Wrap-around:** cycle enough bytes to move `rd_ptr` to 14, then write 4 bytes 0xA0–0xA3. `ibuf_data` must show them contiguously across the wrap.
5. **Over-shift:** with `cnt`=2, apply shift=5. Next cycle: `cnt`=0, `fetch_valid`=0, `ibuf_ovf_err`=1.
6. **Flush with write:** assert flush together with a 4-byte write and shift=2. Next cycle: `cnt`=0 and `fetch_valid`=0. Then pulse `reset_l` low mid-stream: outputs go to reset values asynchronously.
